// File: rtl/minos_pkg.sv
// Shared types for the Minos load/store unit: access size codes, FSM states, alignment helper.
package minos_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_R = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  // Reserved size behaves as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Word-wide req/ack data memory bus between the LSU (master) and data memory (slave).
interface lsu_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_bus_ctrl_lane_align.sv
// Combinational byte-lane steering: size/offset -> byte enables, store data replication,
// load lane select with sign or zero extension.
module lsu_lane_align
  import minos_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        ls,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] rsh;
  logic [15:0] hsel;

  always_comb begin
    rsh       = rdata >> {off, 3'b000};
    hsel      = off[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rdata;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{ls & rsh[7]}}, rsh[7:0]};
      end
      SZ_H: begin
        // Halfword lane picked by off[1] alone; off[0] is a don't-care here.
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{ls & hsel[15]}}, hsel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus sequencer: one bus transaction per core memory op with ack timeout.
// Optional MINOS_LSU_MISALIGN_TRAP_EN: misaligned half/word ops error out without touching the bus.
module lsu_bus_ctrl
  import minos_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_size,
  input  logic          cpu_ls,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          cpu_err,
  lsu_bus_ctrl_if.master bus
);

  // Timeout fires on the cycle the timer would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] TLAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  lsu_state_t           state, nxt;
  logic [TIMEOUT_W-1:0] timer;
  logic [1:0]           size_q, off_q;
  logic                 ls_q, err_q, mis, timeout;
  logic [3:0]           al_be;
  logic [31:0]          al_wdata, al_rdata;

`ifdef MINOS_LSU_MISALIGN_TRAP_EN
  assign mis = misaligned(cpu_size, cpu_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign timeout = (timer == TLAST);

  // IDLE steers the incoming op for enables/wdata; BUSY steers the latched op for load data.
  lsu_lane_align u_align (
    .size      ((state == IDLE) ? cpu_size : size_q),
    .off       ((state == IDLE) ? cpu_addr[1:0] : off_q),
    .ls        (ls_q),
    .wdata     (cpu_wdata),
    .rdata     (bus.rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (cpu_req) nxt = mis ? DONE : BUSY;
      BUSY:    if (bus.ack || timeout) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = cpu_req & (state != DONE);
    cpu_err   = (state == DONE) & err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.be    <= '0;
      bus.wdata <= '0;
      cpu_rdata <= '0;
      err_q     <= 1'b0;
      timer     <= '0;
      size_q    <= '0;
      off_q     <= '0;
      ls_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err_q <= 1'b0;
          if (cpu_req && mis) begin
            cpu_rdata <= '0;
            err_q     <= 1'b1;
          end else if (cpu_req) begin
            bus.req   <= 1'b1;
            bus.we    <= cpu_we;
            bus.addr  <= {cpu_addr[31:2], 2'b00};
            bus.be    <= al_be;
            bus.wdata <= al_wdata;
            size_q    <= cpu_size;
            off_q     <= cpu_addr[1:0];
            ls_q      <= cpu_ls;
            timer     <= '0;
          end
        end
        BUSY: begin
          // A late ack still beats the timeout in the same cycle.
          if (bus.ack) begin
            bus.req   <= 1'b0;
            cpu_rdata <= al_rdata;
          end else if (timeout) begin
            bus.req   <= 1'b0;
            cpu_rdata <= '0;
            err_q     <= 1'b1;
            timer     <= timer + 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
